// File: rtl/linear_network_unicast_sched.sv
// Credit-based round-robin scheduler feeding a linear unicast network.
// One request per cycle is forwarded; per-destination credits throttle issue.
module linear_network_unicast_sched #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_NODE   = 4,
  parameter  int NUM_REQ    = 4,
  parameter  int NUM_CREDIT = 2,
  localparam int CMD_W      = (NUM_NODE > 1) ? $clog2(NUM_NODE) : 1,
  localparam int CRD_W      = $clog2(NUM_CREDIT + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_en,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ*CMD_W-1:0]    i_req_dest,
  output logic [NUM_REQ-1:0]          o_req_ready,
  input  logic [NUM_NODE-1:0]         i_credit_return,
  output logic                        o_net_valid,
  output logic [DATA_WIDTH-1:0]       o_net_data,
  output logic [CMD_W-1:0]            o_net_cmd,
  output logic                        o_net_en,
  output logic [NUM_NODE*CRD_W-1:0]   o_credit,
  output logic [1:0]                  o_err
);

  localparam int RQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEST_SPACE = 1 << CMD_W;
  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(NUM_CREDIT);

  logic [CMD_W-1:0]      w_dest [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_data [NUM_REQ];
  logic [NUM_REQ-1:0]    w_dest_ok;
  logic [NUM_REQ-1:0]    w_elig;
  logic [DEST_SPACE-1:0] w_crd_avail;
  logic [NUM_NODE-1:0]   w_crd_full;
  logic [NUM_NODE-1:0]   w_dec;
  logic                  w_found;
  logic                  w_xfer;
  logic [RQ_W-1:0]       w_idx;
  logic [RQ_W-1:0]       w_win;
  logic [CMD_W-1:0]      w_win_dest;
  logic [DATA_WIDTH-1:0] w_win_data;
  logic                  w_bad_dest;
  logic                  w_overflow;

  logic [CRD_W-1:0]      r_credit [NUM_NODE];
  logic [RQ_W-1:0]       r_last_grant;
  logic [1:0]            r_err;

  // Destinations outside the node range map to "no credit" so they never win.
  always_comb begin
    w_crd_avail = '0;
    w_crd_full  = '0;
    for (int n = 0; n < NUM_NODE; n++) begin
      w_crd_avail[n] = (r_credit[n] != '0);
      w_crd_full[n]  = (r_credit[n] == CRD_MAX);
    end
  end

  always_comb begin
    w_dest_ok = '0;
    w_elig    = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      w_dest[r]    = i_req_dest[r*CMD_W +: CMD_W];
      w_data[r]    = i_req_data[r*DATA_WIDTH +: DATA_WIDTH];
      w_dest_ok[r] = (int'(w_dest[r]) < NUM_NODE);
      w_elig[r]    = i_en & i_req_valid[r] & w_dest_ok[r] & w_crd_avail[w_dest[r]];
    end
  end

  // Round-robin: scan starting one past the previous winner.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = RQ_W'((int'(r_last_grant) + k) % NUM_REQ);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_xfer      = rst_n & w_found;
    w_win_dest  = w_dest[w_win];
    w_win_data  = w_data[w_win];
    o_req_ready = w_xfer ? (NUM_REQ'(1) << w_win) : '0;
  end

  always_comb begin
    w_dec = '0;
    for (int n = 0; n < NUM_NODE; n++) begin
      w_dec[n] = w_xfer && (int'(w_win_dest) == n);
    end
    w_overflow = |(i_credit_return & ~w_dec & w_crd_full);
    w_bad_dest = i_en & |(i_req_valid & ~w_dest_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= RQ_W'(NUM_REQ - 1);
      o_net_valid  <= 1'b0;
      o_net_data   <= '0;
      o_net_cmd    <= '0;
      o_net_en     <= 1'b0;
    end else begin
      o_net_valid <= w_xfer;
      o_net_en    <= i_en;
      if (w_xfer) begin
        r_last_grant <= w_win;
        o_net_data   <= w_win_data;
        o_net_cmd    <= w_win_dest;
      end
    end
  end

  // A same-cycle issue and return cancel; a return into a full counter saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_NODE; n++) begin
        r_credit[n] <= CRD_MAX;
      end
      r_err <= 2'b00;
    end else begin
      for (int n = 0; n < NUM_NODE; n++) begin
        if (w_dec[n] && !i_credit_return[n]) begin
          r_credit[n] <= r_credit[n] - 1'b1;
        end else if (!w_dec[n] && i_credit_return[n] && !w_crd_full[n]) begin
          r_credit[n] <= r_credit[n] + 1'b1;
        end
      end
      r_err <= r_err | {w_overflow, w_bad_dest};
    end
  end

  always_comb begin
    o_credit = '0;
    for (int n = 0; n < NUM_NODE; n++) begin
      o_credit[n*CRD_W +: CRD_W] = r_credit[n];
    end
    o_err = r_err;
  end

endmodule

// File: tb/tb_linear_network_unicast_sched.sv
// Self-checking bench: directed vector table, hand sequences for reset/error
// corners, and randomized traffic compared against a behavioural model.
module tb_linear_network_unicast_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_en;
  logic [3:0]   i_req_valid;
  logic [127:0] i_req_data;
  logic [7:0]   i_req_dest;
  logic [3:0]   o_req_ready;
  logic [3:0]   i_credit_return;
  logic         o_net_valid;
  logic [31:0]  o_net_data;
  logic [1:0]   o_net_cmd;
  logic         o_net_en;
  logic [7:0]   o_credit;
  logic [1:0]   o_err;

  logic         en3;
  logic [3:0]   valid3;
  logic [127:0] data3;
  logic [7:0]   dest3;
  logic [3:0]   ready3;
  logic [2:0]   ret3;
  logic         nv3;
  logic [31:0]  ndata3;
  logic [1:0]   ncmd3;
  logic         nen3;
  logic [5:0]   credit3;
  logic [1:0]   err3;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  linear_network_unicast_sched dut (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_req_valid(i_req_valid),
    .i_req_data(i_req_data), .i_req_dest(i_req_dest), .o_req_ready(o_req_ready),
    .i_credit_return(i_credit_return), .o_net_valid(o_net_valid),
    .o_net_data(o_net_data), .o_net_cmd(o_net_cmd), .o_net_en(o_net_en),
    .o_credit(o_credit), .o_err(o_err)
  );

  linear_network_unicast_sched #(.NUM_NODE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_en(en3), .i_req_valid(valid3),
    .i_req_data(data3), .i_req_dest(dest3), .o_req_ready(ready3),
    .i_credit_return(ret3), .o_net_valid(nv3),
    .o_net_data(ndata3), .o_net_cmd(ncmd3), .o_net_en(nen3),
    .o_credit(credit3), .o_err(err3)
  );

  typedef struct {
    logic       en;
    logic [3:0] valid;
    logic [7:0] dest;
    logic [3:0] ret;
    logic [3:0] ready;
    logic       nv;
    logic [1:0] cmd;
    logic [31:0] data;
    logic [7:0] credit;
  } vec_t;

  vec_t tbl[$];

  int          m_cred[4];
  int          m_last;
  logic        m_nv;
  logic [31:0] m_data;
  logic [1:0]  m_cmd;
  logic        m_en;
  logic [1:0]  m_err;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic modelReset();
    for (int n = 0; n < 4; n++) m_cred[n] = 2;
    m_last = 3;
    m_nv = 1'b0;
    m_data = '0;
    m_cmd = '0;
    m_en = 1'b0;
    m_err = 2'b00;
  endtask

  function automatic int modelWinner();
    for (int k = 1; k <= 4; k++) begin
      int r = (m_last + k) % 4;
      int d = int'(i_req_dest[r*2 +: 2]);
      if (i_en && i_req_valid[r] && m_cred[d] > 0) return r;
    end
    return -1;
  endfunction

  function automatic logic [7:0] modelCredit();
    logic [7:0] v = '0;
    for (int n = 0; n < 4; n++) v[n*2 +: 2] = 2'(m_cred[n]);
    return v;
  endfunction

  task automatic modelStep(input int win);
    int d = (win >= 0) ? int'(i_req_dest[win*2 +: 2]) : -1;
    m_nv = (win >= 0);
    m_en = i_en;
    if (win >= 0) begin
      m_last = win;
      m_data = i_req_data[win*32 +: 32];
      m_cmd = 2'(d);
    end
    for (int n = 0; n < 4; n++) begin
      bit take = (d == n);
      bit give = i_credit_return[n];
      if (take && !give) m_cred[n]--;
      else if (give && !take) begin
        if (m_cred[n] == 2) m_err[1] = 1'b1;
        else m_cred[n]++;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    i_en = v.en;
    i_req_valid = v.valid;
    i_req_dest = v.dest;
    i_credit_return = v.ret;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    i_en = 1'b1;
    i_req_valid = 4'hF;
    i_req_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    i_req_dest = 8'hE4;
    i_credit_return = '0;
    en3 = 1'b1; valid3 = '0; data3 = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    dest3 = '0; ret3 = '0;

    tbl.push_back('{1'b1, 4'hF, 8'hE4, 4'h0, 4'h1, 1'b1, 2'd0, 32'hA0, 8'hA9});
    tbl.push_back('{1'b1, 4'hF, 8'hE4, 4'h0, 4'h2, 1'b1, 2'd1, 32'hA1, 8'hA5});
    tbl.push_back('{1'b1, 4'hF, 8'hE4, 4'h0, 4'h4, 1'b1, 2'd2, 32'hA2, 8'h95});
    tbl.push_back('{1'b1, 4'hF, 8'hE4, 4'h0, 4'h8, 1'b1, 2'd3, 32'hA3, 8'h55});
    tbl.push_back('{1'b1, 4'h0, 8'hE4, 4'h0, 4'h0, 1'b0, 2'd3, 32'hA3, 8'h55});
    tbl.push_back('{1'b1, 4'h0, 8'hE4, 4'hF, 4'h0, 1'b0, 2'd3, 32'hA3, 8'hAA});
    tbl.push_back('{1'b1, 4'h2, 8'h08, 4'h0, 4'h2, 1'b1, 2'd2, 32'hA1, 8'h9A});
    tbl.push_back('{1'b1, 4'h2, 8'h08, 4'h0, 4'h2, 1'b1, 2'd2, 32'hA1, 8'h8A});
    tbl.push_back('{1'b1, 4'h2, 8'h08, 4'h0, 4'h0, 1'b0, 2'd2, 32'hA1, 8'h8A});
    tbl.push_back('{1'b1, 4'h2, 8'h08, 4'h0, 4'h0, 1'b0, 2'd2, 32'hA1, 8'h8A});
    tbl.push_back('{1'b1, 4'h2, 8'h08, 4'h4, 4'h0, 1'b0, 2'd2, 32'hA1, 8'h9A});
    tbl.push_back('{1'b1, 4'h2, 8'h08, 4'h0, 4'h2, 1'b1, 2'd2, 32'hA1, 8'h8A});
    tbl.push_back('{1'b1, 4'h0, 8'h08, 4'h4, 4'h0, 1'b0, 2'd2, 32'hA1, 8'h9A});
    tbl.push_back('{1'b1, 4'h0, 8'h08, 4'h4, 4'h0, 1'b0, 2'd2, 32'hA1, 8'hAA});
    tbl.push_back('{1'b1, 4'h1, 8'h01, 4'h0, 4'h1, 1'b1, 2'd1, 32'hA0, 8'hA6});
    tbl.push_back('{1'b1, 4'h1, 8'h01, 4'h2, 4'h1, 1'b1, 2'd1, 32'hA0, 8'hA6});
    tbl.push_back('{1'b1, 4'h0, 8'h01, 4'h2, 4'h0, 1'b0, 2'd1, 32'hA0, 8'hAA});
    tbl.push_back('{1'b0, 4'hF, 8'hE4, 4'h0, 4'h0, 1'b0, 2'd1, 32'hA0, 8'hAA});

    #12;
    checkOutput("rst_ready", o_req_ready, 4'h0);
    checkOutput("rst_nv", o_net_valid, 1'b0);
    checkOutput("rst_data", o_net_data, 32'h0);
    checkOutput("rst_cmd", o_net_cmd, 2'd0);
    checkOutput("rst_en", o_net_en, 1'b0);
    checkOutput("rst_credit", o_credit, 8'hAA);
    checkOutput("rst_err", o_err, 2'b00);
    i_req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      applyStimulus(tbl[i]);
      #1;
      checkOutput($sformatf("tbl%0d_ready", i), o_req_ready, tbl[i].ready);
      @(posedge clk);
      #1;
      checkOutput($sformatf("tbl%0d_nv", i), o_net_valid, tbl[i].nv);
      checkOutput($sformatf("tbl%0d_cmd", i), o_net_cmd, tbl[i].cmd);
      checkOutput($sformatf("tbl%0d_data", i), o_net_data, tbl[i].data);
      checkOutput($sformatf("tbl%0d_credit", i), o_credit, tbl[i].credit);
      checkOutput($sformatf("tbl%0d_en", i), o_net_en, tbl[i].en);
    end
    checkOutput("tbl_err", o_err, 2'b00);

    // Three-node build: destination 3 is out of range and must never issue.
    i_en = 1'b1; i_req_valid = '0; i_credit_return = '0;
    @(negedge clk);
    valid3 = 4'h3; dest3 = 8'h03;
    #1 checkOutput("n3_ready0", ready3, 4'h2);
    @(negedge clk);
    #1 checkOutput("n3_ready1", ready3, 4'h2);
    checkOutput("n3_err", err3, 2'b01);
    @(negedge clk);
    #1 checkOutput("n3_ready2", ready3, 4'h0);
    checkOutput("n3_credit0", credit3[1:0], 2'd0);
    valid3 = '0;

    // Return into a full counter saturates and latches the overflow flag.
    @(negedge clk);
    i_credit_return = 4'h1;
    @(posedge clk);
    #1;
    checkOutput("ovf_credit", o_credit, 8'hAA);
    checkOutput("ovf_err", o_err, 2'b10);
    @(negedge clk);
    i_credit_return = '0;
    repeat (3) @(negedge clk);
    checkOutput("ovf_sticky", o_err, 2'b10);
    i_req_valid = 4'hF;
    rst_n = 1'b0;
    #1;
    checkOutput("ovf_rst_err", o_err, 2'b00);
    checkOutput("ovf_rst_ready", o_req_ready, 4'h0);
    @(negedge clk);
    i_req_valid = '0;
    rst_n = 1'b1;

    // Reset landing the cycle after a grant drops the in-flight entry.
    @(negedge clk);
    i_req_valid = 4'h1; i_req_dest = 8'h00;
    #1 checkOutput("mid_ready", o_req_ready, 4'h1);
    @(posedge clk);
    #1 checkOutput("mid_nv_pre", o_net_valid, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_nv_rst", o_net_valid, 1'b0);
    checkOutput("mid_credit", o_credit, 8'hAA);
    checkOutput("mid_ready_rst", o_req_ready, 4'h0);
    @(negedge clk);
    i_req_valid = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 checkOutput($sformatf("mid_post%0d", c), o_net_valid, 1'b0);
    end

    // Randomized traffic against the behavioural model.
    doReset();
    modelReset();
    for (int c = 0; c < 400; c++) begin
      int win;
      logic [3:0] exp_ready;
      @(negedge clk);
      i_en = ($urandom_range(0, 9) != 0);
      i_req_valid = 4'($urandom);
      i_req_dest = 8'($urandom);
      i_req_data = {$urandom, $urandom, $urandom, $urandom};
      for (int n = 0; n < 4; n++) i_credit_return[n] = ($urandom_range(0, 3) == 0);
      #1;
      win = modelWinner();
      exp_ready = (win >= 0) ? (4'h1 << win) : 4'h0;
      checkOutput($sformatf("rnd%0d_ready", c), o_req_ready, exp_ready);
      modelStep(win);
      @(posedge clk);
      #1;
      checkOutput($sformatf("rnd%0d_nv", c), o_net_valid, m_nv);
      checkOutput($sformatf("rnd%0d_data", c), o_net_data, m_data);
      checkOutput($sformatf("rnd%0d_cmd", c), o_net_cmd, m_cmd);
      checkOutput($sformatf("rnd%0d_en", c), o_net_en, m_en);
      checkOutput($sformatf("rnd%0d_credit", c), o_credit, modelCredit());
      checkOutput($sformatf("rnd%0d_err", c), o_err, m_err);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/linear_network_unicast_sched.md
LINEAR_NETWORK_UNICAST_SCHED -- requirements
Module: linear_network_unicast_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width.
REQ-002 SHALL have parameter NUM_NODE, default 4, destination count; CMD_W = $clog2(NUM_NODE).
REQ-003 SHALL have parameter NUM_REQ, default 4, requester count.
REQ-004 SHALL have parameter NUM_CREDIT, default 2, per-node credit depth; CRD_W = $clog2(NUM_CREDIT+1).
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port i_en, input, 1: scheduling enable.
REQ-008 SHALL have port i_req_valid, input, NUM_REQ: per-requester valid.
REQ-009 SHALL have port i_req_data, input, NUM_REQ*DATA_WIDTH: requester r payload at [r*DATA_WIDTH+:DATA_WIDTH].
REQ-010 SHALL have port i_req_dest, input, NUM_REQ*CMD_W: requester r destination at [r*CMD_W+:CMD_W].
REQ-011 SHALL have port o_req_ready, output, NUM_REQ: one-hot grant.
REQ-012 SHALL have port i_credit_return, input, NUM_NODE: per-node credit return pulse.
REQ-013 SHALL have ports o_net_valid (1), o_net_data (DATA_WIDTH), o_net_cmd (CMD_W), o_net_en (1), all outputs, driving the linear unicast network i_valid/i_data_bus/i_cmd/i_en.
REQ-014 SHALL have port o_credit, output, NUM_NODE*CRD_W: per-node credit counts.
REQ-015 SHALL have port o_err, output, 2: sticky flags, bit0 bad destination, bit1 credit overflow.

Function
REQ-016 Request r SHALL be eligible when i_en=1, i_req_valid[r]=1, dest<NUM_NODE, and credit[dest]>0.
REQ-017 Arbitration SHALL be round-robin: search starts at last_grant+1 mod NUM_REQ; first eligible wins.
REQ-018 o_req_ready SHALL be combinational, at most one bit high, high only for the winner; transfer occurs when valid and ready are both high.
REQ-019 last_grant SHALL update to the winner only on a transfer cycle; otherwise hold.
REQ-020 On transfer, o_net_data/o_net_cmd SHALL load payload/destination and o_net_valid SHALL be 1 the following cycle (latency 1); with no transfer, o_net_valid SHALL be 0 and o_net_data/o_net_cmd SHALL hold.
REQ-021 Back-to-back transfers SHALL be supported, one per cycle; no bubble is required.
REQ-022 o_net_en SHALL be a register equal to i_en delayed one cycle.
REQ-023 Credit counter SHALL decrement on a transfer to that node, increment on i_credit_return, and hold when both occur in the same cycle.
REQ-024 A return at credit=NUM_CREDIT with no same-cycle transfer SHALL leave the count saturated and set o_err[1].
REQ-025 A valid request with dest>=NUM_NODE SHALL never be granted and SHALL set o_err[0] while i_en=1.
REQ-026 With i_en=0, there SHALL be no grants and credit returns SHALL still be counted.
REQ-027 o_err bits SHALL stay set until reset.

Reset
REQ-028 On rst_n low, asynchronously: o_net_valid=0, o_net_data=0, o_net_cmd=0, o_net_en=0, every credit=NUM_CREDIT, last_grant=NUM_REQ-1, o_err=0; o_req_ready SHALL be 0 while in reset.
REQ-029 Reset asserted mid-transfer SHALL drop the in-flight entry; no o_net_valid pulse SHALL follow reset release.

Verification (DATA_WIDTH=32, NUM_NODE=4, NUM_REQ=4, NUM_CREDIT=2)
REQ-030 Reset release, all four valid, dest=0..3, data=0xA0..0xA3, held -> grants r0,r1,r2,r3 on consecutive cycles; o_net_valid pulses carry cmd 0..3 and data 0xA0..0xA3, each one cycle after its grant.
REQ-031 r1 only, dest=2, held 4 cycles, no returns -> two grants, then ready=0 with credit[2]=0; a pulse on i_credit_return[2] -> grant the next cycle.
REQ-032 Transfer to node 1 in the same cycle as i_credit_return[1] at credit=1 -> credit[1] stays 1.
REQ-033 i_credit_return[0] at credit=2 with no transfer -> credit[0]=2 and o_err[1]=1 until reset.
REQ-034 NUM_NODE=3 build, r0 dest=3 -> never granted and o_err[0]=1; r1 dest=0 still granted.
REQ-035 rst_n low in the cycle after a grant -> o_net_valid=0 immediately, credits back to 2, and no pulse after release.
